write_port_arbiter: RTL



---
 rtl/write_arb_pkg.sv | 15 +
 rtl/write_arb_rr_pick.sv | 41 ++++
 rtl/write_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/write_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package write_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;
    localparam int BURST_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/write_arb_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after start_in, wrapping.
module write_arb_rr_pick
    import write_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [IDX_W-1:0]   start_in,
    output logic               valid_out,
    output logic [IDX_W-1:0]   winner_out
);

    localparam int               SUM_W  = IDX_W + 1;
    localparam logic [SUM_W-1:0] N_WRAP = SUM_W'(NUM_REQ);

    logic [IDX_W-1:0]   w_rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_rot_req;

    // Slot gi of the rotated view holds requester (start + gi) mod NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [SUM_W-1:0] w_sum;
            assign w_sum         = {1'b0, start_in} + SUM_W'(gi);
            assign w_rot_idx[gi] = (w_sum >= N_WRAP) ? IDX_W'(w_sum - N_WRAP) : w_sum[IDX_W-1:0];
            assign w_rot_req[gi] = req_in[w_rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        valid_out  = |req_in;
        winner_out = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot_req[i]) begin
                winner_out = w_rot_idx[i];
            end
        end
    end

endmodule

// File: rtl/write_port_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; never writes while full.
// Define WRITE_ARB_BURST_EN to let an owner keep the grant for up to MAX_BURST writes.
module write_port_arbiter
    import write_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          w_clk_in,
    input  logic                          w_reset_n_in,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    input  logic                          fifo_full_in,
    output logic [NUM_REQ-1:0]            ack_out,
    output logic [NUM_REQ-1:0]            grant_out,
    output logic                          w_request_out,
    output logic [DATA_WIDTH-1:0]         w_data_out
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam int               CNT_EXT_W = BURST_CNT_W + 1;

    arb_state_t             r_state, w_state_next;
    logic [IDX_W-1:0]       r_owner, w_owner_next;
    logic [IDX_W-1:0]       r_rr_ptr, w_rr_ptr_next;
    logic [BURST_CNT_W-1:0] r_burst_cnt, w_burst_cnt_next;

    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [IDX_W-1:0]       w_pick_after;
    logic                   w_owner_req;
    logic                   w_fire;
    logic                   w_burst_done;
    logic                   w_rearb;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic [DATA_WIDTH-1:0]  w_slot [NUM_REQ];

    write_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_in     (req_in),
        .start_in   (r_rr_ptr),
        .valid_out  (w_pick_valid),
        .winner_out (w_pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign w_slot[gi]     = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_owner_oh[gi] = (r_owner == IDX_W'(gi));
        end
    endgenerate

    assign w_pick_after = (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + 1'b1;
    assign w_owner_req  = req_in[r_owner];
    assign w_fire       = (r_state == GRANT) && w_owner_req && !fifo_full_in;

`ifdef WRITE_ARB_BURST_EN
    assign w_burst_done = (CNT_EXT_W'(r_burst_cnt) + CNT_EXT_W'(1)) >= CNT_EXT_W'(MAX_BURST);
`else
    // Every fire ends the grant, so the counter is never advanced and stays 0.
    logic [BURST_CNT_W-1:0] w_unused_max_burst;
    assign w_unused_max_burst = BURST_CNT_W'(MAX_BURST);
    assign w_burst_done       = 1'b1;
`endif

    assign w_request_out = w_fire;
    assign ack_out       = w_fire ? w_owner_oh : '0;
    assign grant_out     = (r_state != IDLE) ? w_owner_oh : '0;
    assign w_data_out    = (r_state != IDLE) ? w_slot[r_owner] : '0;

    always_comb begin
        w_state_next     = r_state;
        w_owner_next     = r_owner;
        w_rr_ptr_next    = r_rr_ptr;
        w_burst_cnt_next = r_burst_cnt;
        w_rearb          = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_rearb = 1'b1;
            end
            GRANT: begin
                if (!w_owner_req) begin
                    w_rearb = 1'b1;
                end else if (fifo_full_in) begin
                    w_state_next = STALL;
                end else if (w_burst_done) begin
                    w_rearb = 1'b1;
                end else begin
                    w_burst_cnt_next = r_burst_cnt + 1'b1;
                end
            end
            STALL: begin
                if (!w_owner_req) begin
                    w_rearb = 1'b1;
                end else if (!fifo_full_in) begin
                    w_state_next = GRANT;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // The current owner's request is still visible here, so after a fire it
        // is scanned last from rr_ptr and only wins again when it is alone.
        if (w_rearb) begin
            w_burst_cnt_next = '0;
            if (w_pick_valid) begin
                w_state_next  = GRANT;
                w_owner_next  = w_pick_idx;
                w_rr_ptr_next = w_pick_after;
            end else begin
                w_state_next  = IDLE;
            end
        end
    end

    always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
        if (!w_reset_n_in) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_burst_cnt <= w_burst_cnt_next;
        end
    end

endmodule
